qpsk_frame_sync: RTL and testbench

Receive-side frame synchronizer for the QPSK link. Takes the serial bit stream recovered by the QPSK demodulator (one strobe per decided bit), hunts for the 8-bit frame header, collects the payload, checks the 8-bit tail and presents each good frame as a 40-bit parallel word. It is the counterpart of the transmit-side framing that builds `{header, payload, tail}` words for the modulator. It also reports lock status and an error count.

---
 rtl/qpsk_frame_sync.sv | 198 +++++++++++++++++++
 tb/tb_qpsk_frame_sync.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync
// Receive-side frame synchronizer for the QPSK link. Takes the serial bit
// stream from the demodulator (one strobe per decided bit), hunts for the
// 8-bit header, collects the payload, checks the 8-bit tail and presents
// each good frame as a parallel word. Also tracks lock status and counts
// bad frames.
//
// Frame on the wire, MSB first: {HEAD[7:0], payload[PAY_W-1:0], TAIL[7:0]}.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   bit_in     in   recovered bit, meaningful only while bit_vld=1
//   bit_vld    in   one-cycle strobe per recovered bit, arbitrary gaps
//   para_out   out  last good frame (PAY_W+16 bits), MSB = first bit received
//   payload    out  para_out[PAY_W+7:8]
//   frame_vld  out  one-cycle pulse in the cycle para_out updates
//   locked     out  frame lock indicator
//   err_cnt    out  bad-frame count, saturates at 255
//   dbg_state  out  FSM state: 0=HUNT, 1=PAY, 2=TAIL, 3=HEAD
//
// Input handshake: bit_vld/bit_in form a valid-only stream with no
// back-pressure. A bit is consumed on every rising clk edge where
// bit_vld=1; edges with bit_vld=0 leave every register untouched (apart
// from frame_vld, which is a single-cycle pulse).

module qpsk_frame_sync #(
  parameter logic [7:0] HEAD   = 8'hFF,
  parameter logic [7:0] TAIL   = 8'hFF,
  parameter int         PAY_W  = 24,
  parameter int         LOCK_N = 2,
  parameter int         LOSS_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_vld,
  output logic [PAY_W+15:0] para_out,
  output logic [PAY_W-1:0]  payload,
  output logic              frame_vld,
  output logic              locked,
  output logic [7:0]        err_cnt,
  output logic [1:0]        dbg_state
);

  localparam int         FRM_W    = PAY_W + 16;
  localparam logic [5:0] PAY_LAST = 6'(PAY_W - 1);
  localparam logic [5:0] BYTE_END = 6'd7;
  localparam logic [5:0] HUNT_MIN = 6'd8;
  localparam logic [3:0] LOCK_C   = 4'(LOCK_N);
  localparam logic [3:0] LOSS_C   = 4'(LOSS_N);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_PAY  = 2'd1,
    S_TAIL = 2'd2,
    S_HEAD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [FRM_W-1:0] sr_q, sr_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [FRM_W-1:0] para_q, para_d;
  logic             fvld_q, fvld_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_q, err_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;

  logic [FRM_W-1:0] sr_shift;
  logic [7:0]       byte_new;
  logic [5:0]       cnt_inc;
  logic             good_frame;
  logic             bad_frame;

  // Shift register contents as they will be after the current bit.
  assign sr_shift = {sr_q[FRM_W-2:0], bit_in};
  assign byte_new = sr_shift[7:0];
  assign cnt_inc  = cnt_q + 6'd1;

  // Framing FSM.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    para_d     = para_q;
    fvld_d     = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    if (bit_vld) begin
      sr_d = sr_shift;
      unique case (state_q)
        S_HUNT: begin
          // cnt holds the number of fresh bits since entering HUNT and
          // saturates at 8, so a header can only be built from bits that
          // arrived after the last rejection.
          cnt_d = (cnt_q >= HUNT_MIN) ? cnt_q : cnt_inc;
          if ((cnt_inc >= HUNT_MIN) && (byte_new == HEAD)) begin
            cnt_d   = 6'd0;
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          cnt_d = cnt_inc;
          if (cnt_q == PAY_LAST) begin
            cnt_d   = 6'd0;
            state_d = S_TAIL;
          end
        end
        S_TAIL: begin
          cnt_d = cnt_inc;
          if (cnt_q == BYTE_END) begin
            cnt_d = 6'd0;
            if (byte_new == TAIL) begin
              good_frame = 1'b1;
              para_d     = sr_shift;
              fvld_d     = 1'b1;
              state_d    = S_HEAD;
            end else begin
              bad_frame = 1'b1;
              state_d   = S_HUNT;
            end
          end
        end
        S_HEAD: begin
          cnt_d = cnt_inc;
          if (cnt_q == BYTE_END) begin
            cnt_d = 6'd0;
            if (byte_new == HEAD) begin
              state_d = S_PAY;
            end else begin
              bad_frame = 1'b1;
              state_d   = S_HUNT;
            end
          end
        end
        default: begin
          cnt_d   = 6'd0;
          state_d = S_HUNT;
        end
      endcase
    end
  end

  // Lock tracking and error counting.
  always_comb begin
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;
    err_d    = err_q;

    if (good_frame) begin
      bad_d  = 4'd0;
      good_d = (good_q >= LOCK_C) ? LOCK_C : good_q + 4'd1;
      if (good_d == LOCK_C) locked_d = 1'b1;
    end

    if (bad_frame) begin
      good_d = 4'd0;
      bad_d  = (bad_q >= LOSS_C) ? LOSS_C : bad_q + 4'd1;
      if (bad_d == LOSS_C) locked_d = 1'b0;
      err_d  = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      sr_q     <= '0;
      cnt_q    <= 6'd0;
      para_q   <= '0;
      fvld_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 8'd0;
      good_q   <= 4'd0;
      bad_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      para_q   <= para_d;
      fvld_q   <= fvld_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign para_out  = para_q;
  assign payload   = para_q[PAY_W+7:8];
  assign frame_vld = fvld_q;
  assign locked    = locked_q;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Testbench for qpsk_frame_sync: directed frames driven bit by bit, a
// bit-level behavioural model of the receiver, a per-cycle compare process
// and hand-computed literal expectations after each scenario.

module tb_qpsk_frame_sync;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_vld;
  logic [39:0] para_out;
  logic [23:0] payload;
  logic        frame_vld;
  logic        locked;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  int n_vec   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  qpsk_frame_sync dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .para_out  (para_out),
    .payload   (payload),
    .frame_vld (frame_vld),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Works on the accepted bit stream only. A single position counter walks
  // through the 40-bit frame once aligned; hunting keeps a count of fresh
  // bits and a sliding 8-bit window. Run lengths are unbounded integers.
  logic [39:0] m_hist  = '0;
  int          m_fresh = 0;   // >=0 while hunting, -1 while aligned
  int          m_pos   = 0;   // bits of the current frame seen while aligned
  logic [39:0] m_para  = '0;
  logic        m_fv    = 1'b0;
  logic        m_lock  = 1'b0;
  int          m_err   = 0;
  int          m_good_run = 0;
  int          m_bad_run  = 0;

  function automatic void m_bad();
    m_err      = (m_err < 255) ? m_err + 1 : 255;
    m_good_run = 0;
    m_bad_run  = m_bad_run + 1;
    if (m_bad_run >= 3) m_lock = 1'b0;
    m_fresh    = 0;
  endfunction

  function automatic void m_step(input logic b);
    m_hist = {m_hist[38:0], b};
    if (m_fresh >= 0) begin
      m_fresh = m_fresh + 1;
      if (m_fresh >= 8 && m_hist[7:0] == 8'hFF) begin
        m_fresh = -1;
        m_pos   = 8;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == 8 && m_hist[7:0] != 8'hFF) begin
        m_bad();
      end else if (m_pos == 40) begin
        if (m_hist[7:0] == 8'hFF) begin
          m_para     = m_hist;
          m_fv       = 1'b1;
          m_good_run = m_good_run + 1;
          m_bad_run  = 0;
          if (m_good_run >= 2) m_lock = 1'b1;
          m_pos      = 0;
        end else begin
          m_bad();
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    m_fv = 1'b0;
    if (rst) begin
      m_hist = '0; m_fresh = 0; m_pos = 0; m_para = '0;
      m_lock = 1'b0; m_err = 0; m_good_run = 0; m_bad_run = 0;
    end else if (bit_vld) begin
      m_step(bit_in);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    chk("cyc_frame_vld", {39'd0, frame_vld}, {39'd0, m_fv});
    chk("cyc_para_out", para_out, m_para);
    chk("cyc_payload", {16'd0, payload}, {16'd0, m_para[31:8]});
    chk("cyc_locked", {39'd0, locked}, {39'd0, m_lock});
    chk("cyc_err_cnt", {32'd0, err_cnt}, 40'(m_err));
    if (frame_vld === 1'b1) n_pulse = n_pulse + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [39:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bit_vld = 1'b0;
      end
      @(negedge clk);
      bit_in  = v[i];
      bit_vld = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_vld = 1'b0;
      bit_in  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bit_vld = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int p0;

  initial begin
    rst     = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_para_out", para_out, 40'h0);
    chk("rst_frame_vld", {39'd0, frame_vld}, 40'h0);
    chk("rst_locked", {39'd0, locked}, 40'h0);
    chk("rst_err_cnt", {32'd0, err_cnt}, 40'h0);
    chk("rst_state_hunt", {38'd0, dbg_state}, 40'h0);

    // 1: single frame, strobe every cycle.
    p0 = n_pulse;
    send_bits(40'hFF_171819_FF, 40, 0);
    idle(1);
    chk("t1_pulse_latency", {39'd0, frame_vld}, 40'h1);
    idle(2);
    chk("t1_para_out", para_out, 40'hFF171819FF);
    chk("t1_payload", {16'd0, payload}, 40'h171819);
    chk("t1_locked", {39'd0, locked}, 40'h0);
    chk("t1_err_cnt", {32'd0, err_cnt}, 40'h0);
    chk("t1_pulses", 40'(n_pulse - p0), 40'd1);

    // 2: idle bits then two back-to-back frames from a fresh hunt. The idle
    // run ends in 0 so it cannot merge with the all-ones header.
    do_reset();
    p0 = n_pulse;
    send_bits(40'h14, 5, 0);            // 10100
    send_bits(40'hFF_171819_FF, 40, 0);
    send_bits(40'hFF_0A0B0C_FF, 40, 0);
    idle(1);
    chk("t2_pulse_latency", {39'd0, frame_vld}, 40'h1);
    idle(2);
    chk("t2_pulses", 40'(n_pulse - p0), 40'd2);
    chk("t2_para_out", para_out, 40'hFF0A0B0CFF);
    chk("t2_locked", {39'd0, locked}, 40'h1);
    chk("t2_err_cnt", {32'd0, err_cnt}, 40'h0);

    // 3: three frames with a bad tail while locked.
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) begin
      send_bits(40'hFF_171819_FE, 40, 0);
      idle(1);
      chk("t3_err_cnt", {32'd0, err_cnt}, 40'(i + 1));
      chk("t3_locked", {39'd0, locked}, (i < 2) ? 40'h1 : 40'h0);
    end
    idle(2);
    chk("t3_pulses", 40'(n_pulse - p0), 40'd0);
    chk("t3_para_kept", para_out, 40'hFF0A0B0CFF);

    // 4: all-ones payload must not cause a resync.
    p0 = n_pulse;
    send_bits(40'hFF_FFFFFF_FF, 40, 0);
    idle(1);
    chk("t4_pulse_latency", {39'd0, frame_vld}, 40'h1);
    idle(2);
    chk("t4_para_out", para_out, 40'hFFFFFFFFFF);
    chk("t4_payload", {16'd0, payload}, 40'hFFFFFF);
    chk("t4_pulses", 40'(n_pulse - p0), 40'd1);
    chk("t4_locked", {39'd0, locked}, 40'h0);
    chk("t4_err_cnt", {32'd0, err_cnt}, 40'd3);

    // 5: strobe every 4th cycle.
    p0 = n_pulse;
    send_bits(40'hFF_171819_FF, 40, 3);
    idle(1);
    chk("t5_pulse_latency", {39'd0, frame_vld}, 40'h1);
    idle(1);
    chk("t5_pulse_single", {39'd0, frame_vld}, 40'h0);
    idle(2);
    chk("t5_para_out", para_out, 40'hFF171819FF);
    chk("t5_pulses", 40'(n_pulse - p0), 40'd1);
    chk("t5_locked", {39'd0, locked}, 40'h1);

    // 6: reset after bit 20 aborts the frame; next full frame delivered.
    p0 = n_pulse;
    send_bits(40'hFF_0A0B0C_FF, 20, 0);
    do_reset();
    chk("t6_err_after_rst", {32'd0, err_cnt}, 40'h0);
    chk("t6_para_after_rst", para_out, 40'h0);
    send_bits(40'hFF_A5C35A_FF, 40, 0);
    idle(1);
    chk("t6_pulse_latency", {39'd0, frame_vld}, 40'h1);
    idle(2);
    chk("t6_pulses", 40'(n_pulse - p0), 40'd1);
    chk("t6_para_out", para_out, 40'hFFA5C35AFF);
    chk("t6_payload", {16'd0, payload}, 40'hA5C35A);
    chk("t6_locked", {39'd0, locked}, 40'h0);
    chk("t6_err_cnt", {32'd0, err_cnt}, 40'h0);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
